nand_logic_pipe: RTL and testbench
==================================

# nand_logic_pipe

Parametrised, pipelined bitwise logic unit in which every operation is built only from 2-input NAND primitives. It generalises the single-bit NAND-derived AND gate to WIDTH-bit vectors and eight selectable operations. A registered pipeline of STAGES stages sits behind a valid/ready handshake, so the unit can be placed between streaming producers and consumers. An output "all-ones" flag and a delivered-result counter are included.

## Interface
- WIDTH, 8, operand and result width in bits (1..32)
- STAGES, 2, number of register stages from input to output (1..4)
- CNT_W, 16, width of the delivered-result counter
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous, active-low reset
- A  input  WIDTH  operand A
- B  input  WIDTH  operand B
- OP  input  3  operation select, sampled with A/B
- in_valid  input  1  A/B/OP valid this cycle
- in_ready  output  1  unit accepts input this cycle
- Y  output  WIDTH  result
- Z  output  1  1 when Y is all ones (AND-reduce of Y)
- out_valid  output  1  Y/Z valid
- out_ready  input  1  consumer accepts Y/Z this cycle
- count  output  CNT_W  number of results delivered since reset

## Operation
- One clock domain (clk). Reset is synchronous and active-low (rst_n).
- Combinational stage, per bit, using only NAND (n(x,y) = ~(x&y)):
  - OP 0 NAND: n(A,B)
  - OP 1 AND: n(n(A,B), n(A,B))
  - OP 2 OR: n(n(A,A), n(B,B))
  - OP 3 NOR: the NAND-inversion of OR
  - OP 4 XOR: standard 4-NAND form, t=n(A,B), n(n(A,t), n(B,t))
  - OP 5 XNOR: the NAND-inversion of XOR
  - OP 6 NOT A: n(A,A)
  - OP 7 PASS A: n(n(A,A), n(A,A))
- Operation select is a mux after the NAND network. Do not use direct &, |, ^, or ~ on operand data outside the n() primitive.
- Z is computed from the same registered data that drives Y and is presented with Y.
- Pipeline uses a global-stall scheme:
  - advance = ~out_valid | out_ready
  - in_ready = advance
- When advance is 1, every stage shifts forward by one. Stage 0 captures {result, in_valid}. Valid bits propagate with the data.
- When advance is 0, all stages hold their contents and inputs are ignored, regardless of in_valid.
- The logic result is computed before stage 0. Stages 1..STAGES-1 are pure delay registers. Y, Z and out_valid come from the last stage.
- A transfer occurs when out_valid & out_ready. count increments by 1 on each transfer and wraps from 2^CNT_W-1 to 0.
- Bubbles (in_valid=0 while advancing) occupy a stage as invalid. They are not compacted.

## Timing
- Reset (rst_n=0 at a rising edge): all stage valids cleared, Y=0, Z=0, out_valid=0, count=0.
- in_ready is combinational from out_valid/out_ready and is 1 during and immediately after reset.
- Reset mid-operation discards all in-flight results. count is not incremented for discarded results.
- Latency: an input accepted at edge k appears at the outputs after edge k+STAGES-1 (visible in cycle k+STAGES-1 to k+STAGES), provided there are no stalls.
- Stall cycles add 1:1 latency.
- Throughput: 1 result per cycle while out_ready=1.
- While out_valid=1 and out_ready=0, Y, Z and out_valid are held stable.
- Simultaneous accept at input and transfer at output in the same cycle is legal and required for full throughput.
- Y/Z are don't-care when out_valid=0 but must not be X after reset.

## Test plan
- Reset: hold rst_n=0 for 3 cycles with in_valid=1 -> out_valid=0, Y=0, Z=0, count=0, in_ready=1.
- Truth table, WIDTH=8, STAGES=2: A=8'hCC, B=8'hAA, OP 0..7, out_ready=1. Required Y values, in order: 77, 88, EE, 11, 66, 99, 33, CC. Z=0 for all. Each result arrives 2 cycles after issue, back-to-back.
- All-ones flag: A=8'hF0, B=8'h0F, OP=2 -> Y=FF, Z=1. Then OP=1 -> Y=00, Z=0.
- Backpressure: stream 5 XOR ops, drop out_ready for 3 cycles mid-stream -> in_ready=0 during the stall, Y held stable, no loss or duplication, all 5 results in order, count=5.
- Reset mid-stream: 2 results in flight, assert rst_n=0 for one edge -> out_valid=0 next cycle, count=0, the in-flight results never appear.
- Counter wrap with CNT_W=4: deliver 17 results -> count reads 15 after the 15th, 0 after the 16th, 1 after the 17th.

Source files
------------

// File: rtl/nand_logic_pipe_if.sv
// Streaming handshake bundle for nand_logic_pipe: operand side (A/B/OP with
// in_valid/in_ready) and result side (Y/Z with out_valid/out_ready, count).
interface nand_logic_pipe_if #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 16
);
   logic [WIDTH-1:0] A;
   logic [WIDTH-1:0] B;
   logic [2:0]       OP;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] Y;
   logic             Z;
   logic             out_valid;
   logic             out_ready;
   logic [CNT_W-1:0] count;

   // Producer/consumer side that drives operands and accepts results
   modport master (
      output A, B, OP, in_valid, out_ready,
      input  in_ready, Y, Z, out_valid, count
   );

   // Logic unit side
   modport slave (
      input  A, B, OP, in_valid, out_ready,
      output in_ready, Y, Z, out_valid, count
   );
endinterface

// File: rtl/nand_logic_pipe.sv
// Pipelined WIDTH-bit logic unit. Every operation is derived from a 2-input
// NAND network; a mux after the network picks the result. A global-stall
// pipeline of STAGES registers carries the result to the output, where an
// all-ones flag and a delivered-result counter are also produced.
module nand_logic_pipe #(
   parameter int WIDTH  = 8,
   parameter int STAGES = 2,
   parameter int CNT_W  = 16
) (
   input logic             clk,
   input logic             rst_n,
   nand_logic_pipe_if.slave io
);

   // The single primitive from which every operation is built.
   function automatic logic [WIDTH-1:0] nand2(input logic [WIDTH-1:0] x,
                                              input logic [WIDTH-1:0] y);
      return ~(x & y);
   endfunction

   // NAND network: each node feeds the next, operands are touched only via nand2
   logic [WIDTH-1:0] nab_s;
   logic [WIDTH-1:0] na_s;
   logic [WIDTH-1:0] nb_s;
   logic [WIDTH-1:0] and_s;
   logic [WIDTH-1:0] or_s;
   logic [WIDTH-1:0] nor_s;
   logic [WIDTH-1:0] xor_s;
   logic [WIDTH-1:0] xnor_s;
   logic [WIDTH-1:0] pass_s;
   logic [WIDTH-1:0] result_s;

   assign nab_s  = nand2(io.A, io.B);
   assign na_s   = nand2(io.A, io.A);
   assign nb_s   = nand2(io.B, io.B);
   assign and_s  = nand2(nab_s, nab_s);
   assign or_s   = nand2(na_s, nb_s);
   assign nor_s  = nand2(or_s, or_s);
   assign xor_s  = nand2(nand2(io.A, nab_s), nand2(io.B, nab_s));
   assign xnor_s = nand2(xor_s, xor_s);
   assign pass_s = nand2(na_s, na_s);

   // Operation select sits after the network
   always_comb begin
      result_s = '0;
      case (io.OP)
         3'd0:    result_s = nab_s;
         3'd1:    result_s = and_s;
         3'd2:    result_s = or_s;
         3'd3:    result_s = nor_s;
         3'd4:    result_s = xor_s;
         3'd5:    result_s = xnor_s;
         3'd6:    result_s = na_s;
         3'd7:    result_s = pass_s;
         default: result_s = nab_s;
      endcase
   end

   // Pipeline storage; index STAGES-1 is the output stage
   logic [STAGES-1:0][WIDTH-1:0] data_r;
   logic [STAGES-1:0]            vld_r;
   logic [CNT_W-1:0]             count_r;
   logic                         advance_s;
   logic                         xfer_s;

   // Whole pipe moves together whenever the output slot is empty or being drained
   assign advance_s = ~vld_r[STAGES-1] | io.out_ready;
   assign xfer_s    = vld_r[STAGES-1] & io.out_ready;

   // Shift data and valid bits forward on advance; bubbles travel as invalid slots
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         data_r <= '0;
         vld_r  <= '0;
      end else if (advance_s) begin
         data_r[0] <= result_s;
         vld_r[0]  <= io.in_valid;
         for (int i = 1; i < STAGES; i++) begin
            data_r[i] <= data_r[i-1];
            vld_r[i]  <= vld_r[i-1];
         end
      end
   end

   // Delivered-result counter, wraps naturally at 2^CNT_W
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         count_r <= '0;
      end else if (xfer_s) begin
         count_r <= count_r + CNT_W'(1);
      end
   end

   assign io.in_ready  = advance_s;
   assign io.Y         = data_r[STAGES-1];
   assign io.Z         = &data_r[STAGES-1];
   assign io.out_valid = vld_r[STAGES-1];
   assign io.count     = count_r;

endmodule

// File: tb/tb_nand_logic_pipe.sv
// Scoreboard bench for nand_logic_pipe (WIDTH=8, STAGES=2, CNT_W=4).
// The driver pushes hand-computed expectations on acceptance; an independent
// monitor pops and compares whenever the unit presents a result.
module tb_nand_logic_pipe;
   localparam int LAT = 1;   // edges from accept to visible output with STAGES=2

   logic clk = 1'b0;
   logic rst_n;
   int   cyc = 0;
   int   n_cmp = 0;
   int   n_fail = 0;

   typedef struct {
      logic [7:0] y;
      logic       z;
      int         ic;
      bit         lat;
   } exp_t;
   exp_t q[$];

   nand_logic_pipe_if #(.WIDTH(8), .CNT_W(4)) bus ();

   nand_logic_pipe #(.WIDTH(8), .STAGES(2), .CNT_W(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .io    (bus.slave)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, required %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Monitor: compare presented results against the queue front
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (rst_n === 1'b1 && bus.out_valid === 1'b1) begin
            if (q.size() == 0) begin
               n_cmp++;
               n_fail++;
               $display("FAIL unexpected_out: got Y=%0h, required no output", bus.Y);
            end else begin
               e = q[0];
               check("y", {24'd0, bus.Y}, {24'd0, e.y});
               check("z", {31'd0, bus.Z}, {31'd0, e.z});
               if (bus.out_ready === 1'b1) begin
                  if (e.lat) check("latency", cyc - e.ic, LAT);
                  void'(q.pop_front());
               end
            end
         end
      end
   end

   // Present one operation; wait (bounded) until accepted. in_valid stays high.
   task automatic issue(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op,
                        input logic [7:0] ey, input logic ez, input bit lat);
      bit   acc;
      exp_t e;
      int   t;
      bus.A = a;
      bus.B = b;
      bus.OP = op;
      bus.in_valid = 1'b1;
      acc = 1'b0;
      t = 0;
      while (!acc && t < 50) begin
         @(negedge clk);
         acc = (bus.in_ready === 1'b1);
         if (acc) begin
            e.y = ey;
            e.z = ez;
            e.ic = cyc + 1;
            e.lat = lat;
            q.push_back(e);
         end
         @(posedge clk);
         #1;
         t++;
      end
      if (!acc) begin
         n_cmp++;
         n_fail++;
         $display("FAIL accept_timeout: got in_ready=0 for 50 cycles, required acceptance");
      end
   endtask

   // Wait (bounded) for all expected results to be delivered
   task automatic drain();
      for (int t = 0; t < 100 && q.size() != 0; t++) @(posedge clk);
      @(posedge clk);
      #1;
      check("drain_left", q.size(), 0);
   endtask

   task automatic reset_pulse();
      rst_n = 1'b0;
      bus.in_valid = 1'b0;
      q.delete();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      check("rst_out_valid", {31'd0, bus.out_valid}, 0);
      check("rst_count", {28'd0, bus.count}, 0);
   endtask

   logic [7:0] tt_y [8] = '{8'h77, 8'h88, 8'hEE, 8'h11, 8'h66, 8'h99, 8'h33, 8'hCC};
   logic [7:0] bp_a [5] = '{8'h12, 8'h5A, 8'hFF, 8'h0F, 8'h80};
   logic [7:0] bp_b [5] = '{8'h34, 8'hA5, 8'hFF, 8'h3C, 8'h01};
   logic [7:0] bp_y [5] = '{8'h26, 8'hFF, 8'h00, 8'h33, 8'h81};
   logic       bp_z [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};

   initial begin
      rst_n = 1'b0;
      bus.A = 8'hCC;
      bus.B = 8'hAA;
      bus.OP = 3'd0;
      bus.in_valid = 1'b1;
      bus.out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("reset_out_valid", {31'd0, bus.out_valid}, 0);
      check("reset_y", {24'd0, bus.Y}, 0);
      check("reset_z", {31'd0, bus.Z}, 0);
      check("reset_count", {28'd0, bus.count}, 0);
      check("reset_in_ready", {31'd0, bus.in_ready}, 1);
      rst_n = 1'b1;
      bus.in_valid = 1'b0;

      // Truth table, back-to-back, latency checked
      for (int i = 0; i < 8; i++) issue(8'hCC, 8'hAA, 3'(i), tt_y[i], 1'b0, 1'b1);
      bus.in_valid = 1'b0;
      drain();
      check("count_tt", {28'd0, bus.count}, 8);

      // All-ones flag
      issue(8'hF0, 8'h0F, 3'd2, 8'hFF, 1'b1, 1'b1);
      issue(8'hF0, 8'h0F, 3'd1, 8'h00, 1'b0, 1'b1);
      bus.in_valid = 1'b0;
      drain();

      // Backpressure: 3-cycle stall in the middle of a 5-op XOR stream
      reset_pulse();
      fork
         begin
            for (int i = 0; i < 5; i++) issue(bp_a[i], bp_b[i], 3'd4, bp_y[i], bp_z[i], 1'b0);
            bus.in_valid = 1'b0;
         end
         begin
            repeat (3) @(posedge clk);
            #1;
            bus.out_ready = 1'b0;
            for (int s = 0; s < 3; s++) begin
               @(negedge clk);
               check("in_ready_stall", {31'd0, bus.in_ready}, 0);
               @(posedge clk);
               #1;
            end
            bus.out_ready = 1'b1;
         end
      join
      drain();
      check("count_bp", {28'd0, bus.count}, 5);

      // Reset with two results in flight: they must never appear
      issue(8'h01, 8'h02, 3'd2, 8'h03, 1'b0, 1'b0);
      issue(8'h04, 8'h08, 3'd2, 8'h0C, 1'b0, 1'b0);
      reset_pulse();
      repeat (6) @(posedge clk);
      #1;
      check("flush_out_valid", {31'd0, bus.out_valid}, 0);
      check("flush_count", {28'd0, bus.count}, 0);

      // Counter wrap with a 4-bit counter
      for (int i = 1; i <= 17; i++) begin
         issue(8'(i), 8'h00, 3'd7, 8'(i), 1'b0, 1'b0);
         bus.in_valid = 1'b0;
         drain();
         check("count_wrap", {28'd0, bus.count}, i % 16);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
